// File: rtl/regfile_sb.sv
// Scoreboarded multi-read-port register file; top index aliases pc + PC_OFFSET.
// Define REGFILE_BYPASS_EN to forward same-cycle writeback data to the read ports.
module regfile_sb #(
  parameter int unsigned DATA_W    = 32,
  parameter int unsigned NUM_REGS  = 16,
  parameter int unsigned NUM_RD    = 2,
  parameter int unsigned ADDR_W    = $clog2(NUM_REGS),
  parameter logic [DATA_W-1:0] PC_OFFSET = DATA_W'(8)
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [DATA_W-1:0]        pc,
  input  logic [NUM_RD*ADDR_W-1:0] ra,
  output logic [NUM_RD*DATA_W-1:0] rd,
  output logic [NUM_RD-1:0]        rd_busy,
  input  logic                     we,
  input  logic [ADDR_W-1:0]        wa,
  input  logic [DATA_W-1:0]        wd,
  input  logic                     issue_valid,
  input  logic [ADDR_W-1:0]        issue_wa,
  output logic                     issue_ready,
  input  logic                     clr_start,
  output logic                     clr_busy
);

  localparam logic [ADDR_W-1:0] PC_IDX   = ADDR_W'(NUM_REGS - 1);
  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NUM_REGS - 2);

  typedef enum logic {IDLE, CLEAR} state_t;

  state_t              state;
  logic [ADDR_W-1:0]   clr_cnt;
  logic [NUM_REGS-1:0] busy;     // top bit (PC alias) is never set
  logic [DATA_W-1:0]   rf [NUM_REGS-1];

  logic idle;
  logic wr_fire;
  logic issue_fire;

  assign idle        = (state == IDLE);
  assign wr_fire     = we && idle && (wa != PC_IDX);
  assign issue_ready = idle && !busy[issue_wa] && (issue_wa != PC_IDX);
  assign issue_fire  = issue_valid && issue_ready;
  assign clr_busy    = (state == CLEAR);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= CLEAR;
      clr_cnt <= '0;
      busy    <= '0;
    end else begin
      case (state)
        IDLE: begin
          // issue is applied after writeback so a same-register issue wins
          if (wr_fire)    busy[wa]       <= 1'b0;
          if (issue_fire) busy[issue_wa] <= 1'b1;
          if (clr_start) begin
            state   <= CLEAR;
            clr_cnt <= '0;
          end
        end
        CLEAR: begin
          if (clr_cnt == LAST_IDX) begin
            state   <= IDLE;
            clr_cnt <= '0;
            busy    <= '0;
          end else begin
            clr_cnt <= clr_cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Storage has no reset; the clear sweep zeroes it.
  always_ff @(posedge clk) begin
    if (state == CLEAR) begin
      rf[clr_cnt] <= '0;
    end else if (wr_fire) begin
      rf[wa] <= wd;
    end
  end

  for (genvar g = 0; g < NUM_RD; g++) begin : g_rd
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
    logic              bsy;

    assign addr = ra[g*ADDR_W +: ADDR_W];

    always_comb begin
      if (addr == PC_IDX) begin
        data = pc + PC_OFFSET;
        bsy  = 1'b0;
      end else begin
        data = rf[addr];
        bsy  = busy[addr];
      end
`ifdef REGFILE_BYPASS_EN
      if (wr_fire && (wa == addr)) begin
        data = wd;
        bsy  = issue_fire && (issue_wa == addr);
      end
`else
`endif
    end

    assign rd[g*DATA_W +: DATA_W] = data;
    assign rd_busy[g]             = bsy;
  end

endmodule
